des_round_engine: RTL and testbench

//  Iterative DES Feistel core between the input and output permutation stages.

---
 rtl/des_round_engine_pkg.sv | 82 ++++++++
 rtl/des_round_engine_if.sv | 14 +
 rtl/des_round_engine_f_function.sv | 30 +++
 rtl/des_round_engine.sv | 85 ++++++++
 tb/tb_des_round_engine.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/des_round_engine_pkg.sv
// DES tables, key-rotation helpers and state encoding shared by the round engine.
// Bit numbering is MSB-first: DES bit 1 is the top bit of each vector.
package des_round_engine_pkg;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t ROUND = 2'd1;
  localparam state_t DONE  = 2'd2;

  // Bit i set: round i rotates the key halves by one position, otherwise by two.
  localparam logic [15:0] SHIFT_ONE = 16'h8103;

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Entry {box, row}; column c sits in nibble c counted from the top.
  localparam logic [63:0] SBOX [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++) o[6'(55 - i)] = k[6'(64 - PC1_TBL[i])];
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - PC2_TBL[i])];
    return o;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] r);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = r[5'(32 - E_TBL[i])];
    return o;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] s);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 32; i++) o[5'(31 - i)] = s[5'(32 - P_TBL[i])];
    return o;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] v, input logic one);
    return one ? {v[26:0], v[27]} : {v[25:0], v[27:26]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] v, input logic one);
    return one ? {v[0], v[27:1]} : {v[1:0], v[27:2]};
  endfunction

endpackage

// File: rtl/des_round_engine_if.sv
// Request/result bundle of the DES round engine: block, key and mode in; pre-output block,
// busy and done out. The master drives requests, the engine is the slave.
interface des_round_engine_if;
  logic        start;
  logic        encrypt;
  logic [63:0] key;
  logic [63:0] des_in;
  logic [63:0] des_curr;
  logic        busy;
  logic        done;

  modport master (output start, encrypt, key, des_in, input des_curr, busy, done);
  modport slave  (input start, encrypt, key, des_in, output des_curr, busy, done);
endinterface

// File: rtl/des_round_engine_f_function.sv
// DES Feistel f-function: expand R, mix in the round key, S-box substitute, permute.
// Purely combinational.
module des_round_engine_f_function
  import des_round_engine_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] ki,
  output logic [31:0] f
);

  logic [47:0] x;
  logic [31:0] sb;
  logic [5:0]  six;
  logic [3:0]  nib;

  always_comb begin
    x   = e_expand(r) ^ ki;
    sb  = '0;
    six = '0;
    nib = '0;
    for (int s = 0; s < 8; s++) begin
      six = 6'(x >> (42 - 6 * s));
      // Outer bits pick the row, inner four bits pick the column nibble.
      nib = 4'(SBOX[{3'(s), six[5], six[0]}] >> (6'd60 - {six[4:1], 2'b00}));
      sb  = {sb[27:0], nib};
    end
    f = p_perm(sb);
  end

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES Feistel core: one round per clock, done 17 cycles after start at NUM_ROUNDS=16.
// Start is accepted only when idle or in the done cycle; requests while busy are dropped.
module des_round_engine
  import des_round_engine_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic            clk,
  input  logic            n_rst,
  des_round_engine_if.slave bus
);

  state_t      state;
  logic        mode;
  logic [31:0] l_q, r_q, f;
  logic [27:0] c_q, d_q, c_rot, d_rot;
  logic [3:0]  round_cnt, sh_idx;
  logic [47:0] ki;
  logic [63:0] curr_q;
  logic        accept, last;

  // Decrypt walks the schedule backwards: round 0 reuses the loaded halves (C16 == C0).
  always_comb begin
    sh_idx = mode ? round_cnt : 4'(5'd16 - {1'b0, round_cnt});
    c_rot  = c_q;
    d_rot  = d_q;
    if (mode) begin
      c_rot = rotl28(c_q, SHIFT_ONE[sh_idx]);
      d_rot = rotl28(d_q, SHIFT_ONE[sh_idx]);
    end else if (round_cnt != 4'd0) begin
      c_rot = rotr28(c_q, SHIFT_ONE[sh_idx]);
      d_rot = rotr28(d_q, SHIFT_ONE[sh_idx]);
    end
    ki = pc2({c_rot, d_rot});
  end

  des_round_engine_f_function u_f (
    .r  (r_q),
    .ki (ki),
    .f  (f)
  );

  assign accept = bus.start && (state == IDLE || state == DONE);
  assign last   = (state == ROUND) && (round_cnt == 4'(NUM_ROUNDS - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      mode      <= 1'b0;
      l_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      round_cnt <= '0;
      curr_q    <= '0;
    end else if (accept) begin
      state          <= ROUND;
      mode           <= bus.encrypt;
      l_q            <= bus.des_in[63:32];
      r_q            <= bus.des_in[31:0];
      {c_q, d_q}     <= pc1(bus.key);
      round_cnt      <= '0;
    end else begin
      case (state)
        ROUND: begin
          l_q       <= r_q;
          r_q       <= l_q ^ f;
          c_q       <= c_rot;
          d_q       <= d_rot;
          round_cnt <= round_cnt + 4'd1;
          if (last) begin
            state  <= DONE;
            curr_q <= {l_q ^ f, r_q};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state == ROUND);
  assign bus.done     = (state == DONE);
  assign bus.des_curr = curr_q;

endmodule

// File: tb/tb_des_round_engine.sv
// Bench for des_round_engine: known answers, protocol corner cases and random traffic
// compared against a subkey-list DES model with its own tables.
module tb_des_round_engine;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] prev_res = '0;

  des_round_engine_if bus ();

  des_round_engine #(.NUM_ROUNDS(16)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int SB [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,   0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,  15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,   3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,  13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,  13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,   1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,  13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,   3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,  14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,  11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,  10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,   4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,  13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,   6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,   1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,   2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  // DES bit n (1-based) of a w-bit value.
  function automatic logic gb(input logic [63:0] x, input int w, input int n);
    return 1'(x >> (w - n));
  endfunction

  function automatic int ip_src(input int j);
    int row, col;
    row = j / 8;
    col = j % 8;
    return ((row < 4) ? 58 + 2 * row : 57 + 2 * (row - 4)) - 8 * col;
  endfunction

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 64; j++) y = {y[62:0], gb(x, 64, ip_src(j))};
    return y;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] y);
    logic [63:0] x;
    x = '0;
    for (int j = 0; j < 64; j++) x = x | (64'(gb(y, 64, j + 1)) << (64 - ip_src(j)));
    return x;
  endfunction

  function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s, o;
    logic [5:0]  six;
    int row, col;
    e = '0;
    for (int j = 0; j < 48; j++) e = {e[46:0], gb(64'(r), 32, ((4 * (j / 6) + j % 6 + 31) % 32) + 1)};
    e = e ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      six = 6'(e >> (42 - 6 * b));
      row = 2 * int'(six[5]) + int'(six[0]);
      col = int'(six[4:1]);
      s = {s[27:0], 4'(SB[b][16 * row + col])};
    end
    o = '0;
    for (int j = 0; j < 32; j++) o = {o[30:0], gb(64'(s), 32, P_T[j])};
    return o;
  endfunction

  // Full 16-round core on an IP-permuted block; decrypt uses the subkey list reversed.
  function automatic logic [63:0] model_des(input logic [63:0] blk, input logic [63:0] key, input logic enc);
    logic [47:0] sk [16];
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [31:0] l, r, t;
    int sh;
    cd = '0;
    for (int j = 0; j < 56; j++) cd = {cd[54:0], gb(key, 64, PC1_T[j])};
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      sh = (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
      c = (c << sh) | (c >> (28 - sh));
      d = (d << sh) | (d >> (28 - sh));
      sk[i] = '0;
      for (int j = 0; j < 48; j++) sk[i] = {sk[i][46:0], gb(64'({c, d}), 56, PC2_T[j])};
    end
    l = blk[63:32];
    r = blk[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ model_f(r, enc ? sk[i] : sk[15 - i]);
      l = t;
    end
    return {r, l};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one request and waits (bounded) for done; inputs are scrambled after the load edge.
  task automatic run_op(input logic [63:0] k, input logic [63:0] d, input logic e, input bit now,
                        input int poke_at, output logic [63:0] res, output int lat,
                        output int busy_n, output logic [63:0] mid);
    if (!now) @(negedge clk);
    bus.start   = 1'b1;
    bus.key     = k;
    bus.des_in  = d;
    bus.encrypt = e;
    lat = 0;
    busy_n = 0;
    mid = '0;
    do begin
      @(negedge clk);
      lat++;
      bus.start   = (lat == poke_at);
      bus.key     = {$urandom, $urandom};
      bus.des_in  = {$urandom, $urandom};
      bus.encrypt = 1'($urandom);
      if (bus.busy) busy_n++;
      if (lat == 8) mid = bus.des_curr;
    end while (!bus.done && lat < 40);
    res = bus.des_curr;
    bus.start = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [63:0] k, input logic [63:0] d, input logic e,
                       input bit now, input int poke_at, output logic [63:0] res);
    int lat, busy_n;
    logic [63:0] mid, exp;
    exp = model_des(d, k, e);
    run_op(k, d, e, now, poke_at, res, lat, busy_n, mid);
    chk({tag, "_res"}, res, exp);
    chk({tag, "_lat"}, 64'(lat), 64'd17);
    chk({tag, "_busy"}, 64'(busy_n), 64'd16);
    chk({tag, "_hold"}, mid, prev_res);
    prev_res = exp;
  endtask

  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] KAT_IN  = 64'hCC00CCFFF0AAF0AA;
  localparam logic [63:0] KAT_OUT = 64'h0A4CD99543423234;

  initial begin
    logic [63:0] r, x;
    int seen;
    bit now;
    bus.start = 1'b0;
    bus.encrypt = 1'b0;
    bus.key = '0;
    bus.des_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_curr", bus.des_curr, 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    n_rst = 1'b1;

    do_op("kat_enc", KAT_KEY, KAT_IN, 1'b1, 1'b0, 0, r);
    chk("kat_enc_const", r, KAT_OUT);
    chk("kat_enc_fp", fp(r), 64'h85E813540F0AB405);
    @(negedge clk);
    chk("done_pulse", 64'(bus.done), 64'd0);

    do_op("kat_dec", KAT_KEY, ip(64'h85E813540F0AB405), 1'b0, 1'b0, 0, r);
    chk("kat_dec_fp", fp(r), 64'h0123456789ABCDEF);

    x = {$urandom, $urandom};
    do_op("weak1", 64'h0101010101010101, ip(x), 1'b1, 1'b0, 0, r);
    do_op("weak2", 64'h0101010101010101, ip(fp(r)), 1'b1, 1'b0, 0, r);
    chk("weak_involution", fp(r), x);

    do_op("start_busy", KAT_KEY, KAT_IN, 1'b1, 1'b0, 5, r);
    chk("start_busy_const", r, KAT_OUT);

    do_op("b2b_a", {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0, 0, r);
    do_op("b2b_b", {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b1, 0, r);

    @(negedge clk);
    bus.start = 1'b1;
    bus.key = {$urandom, $urandom};
    bus.des_in = {$urandom, $urandom};
    bus.encrypt = 1'($urandom);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("rst_mid_busy_before", 64'(bus.busy), 64'd1);
    n_rst = 1'b0;
    #1;
    chk("rst_mid_curr", bus.des_curr, 64'd0);
    chk("rst_mid_busy", 64'(bus.busy), 64'd0);
    chk("rst_mid_done", 64'(bus.done), 64'd0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      seen += int'(bus.done);
    end
    n_rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      seen += int'(bus.done);
    end
    chk("rst_no_done", 64'(seen), 64'd0);
    prev_res = '0;
    do_op("after_rst", {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0, 0, r);

    for (int i = 0; i < 20; i++) begin
      now = ($urandom_range(0, 2) == 0);
      do_op("rand", {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), now, 0, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
